// File: rtl/scan_crypt_engine.sv
// Scan-stream cipher engine: a 128-bit LFSR keystream encrypts or decrypts
// scan beats. A CRC-32 over the plaintext yields a per-session signature.
module scan_crypt_engine #(
  parameter int DATA_W = 8,
  parameter int WARMUP = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              start,
  input  logic              stop,
  input  logic              mode_dec,
  input  logic [127:0]      initial_key,
  input  logic [63:0]       iv,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              dout_valid,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              ready,
  output logic              sig_valid,
  output logic [31:0]       signature
);

  localparam int          CNT_W    = $clog2(WARMUP + 1);
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_FINISH} state_t;

  state_t              state_q, state_d;
  logic [127:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         crc_q, crc_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic [31:0]         signature_q, signature_d;
  logic                sig_valid_q, sig_valid_d;

  logic [127:0]        seed;
  logic [DATA_W-1:0]   ks;
  logic [DATA_W-1:0]   plaintext;

  // One Fibonacci LFSR step, shifting toward the MSB.
  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    return {s[126:0], s[127] ^ s[28] ^ s[26] ^ s[1]};
  endfunction

  // Bit-serial CRC-32 over one beat, MSB of the beat first.
  function automatic logic [31:0] crc_update(input logic [31:0] c_in,
                                             input logic [DATA_W-1:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  assign seed      = initial_key ^ {iv, iv};
  assign ks        = lfsr_q[DATA_W-1:0] ^ lfsr_q[127 -: DATA_W];
  // The CRC always covers plaintext: the input when encrypting, the result when decrypting.
  assign plaintext = mode_q ? (din ^ ks) : din;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; nothing moves while en is low.
  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        S_IDLE:   if (start) state_d = S_WARM;
        S_WARM: begin
          if (stop)                      state_d = S_IDLE;
          else if (cnt_q == CNT_W'(1))   state_d = S_RUN;
        end
        S_RUN:    if (stop) state_d = S_FINISH;
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM status outputs.
  always_comb begin
    busy  = (state_q != S_IDLE);
    ready = (state_q == S_RUN);
  end

  // Datapath next values: hold by default, valid pulses fall back to 0.
  always_comb begin
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    crc_d        = crc_q;
    mode_d       = mode_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    signature_d  = signature_q;
    sig_valid_d  = 1'b0;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // An all-zero seed would lock the LFSR, so substitute 1.
            lfsr_d = (seed == 128'h0) ? 128'h1 : seed;
            cnt_d  = CNT_W'(WARMUP);
            crc_d  = CRC_INIT;
            mode_d = mode_dec;
          end
        end
        S_WARM: begin
          if (!stop) begin
            lfsr_d = lfsr_step(lfsr_q);
            cnt_d  = cnt_q - CNT_W'(1);
          end
        end
        S_RUN: begin
          if (din_valid) begin
            dout_d       = din ^ ks;
            dout_valid_d = 1'b1;
            lfsr_d       = lfsr_step(lfsr_q);
            crc_d        = crc_update(crc_q, plaintext);
          end
        end
        S_FINISH: begin
          signature_d = crc_q;
          sig_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q       <= 128'h0;
      cnt_q        <= '0;
      crc_q        <= CRC_INIT;
      mode_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      signature_q  <= 32'h0;
      sig_valid_q  <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      crc_q        <= crc_d;
      mode_q       <= mode_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      signature_q  <= signature_d;
      sig_valid_q  <= sig_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign signature  = signature_q;
  assign sig_valid  = sig_valid_q;

endmodule
